// File: rtl/serial_add_ctrl.sv
// ============================================================================
// serial_add_ctrl : bit-serial adder, one full-adder bit per clock, LSB first.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port for a - b (cout=1: no borrow).
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so the incoming carry is forced high.
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  // The shared 1-bit full-adder cell
  assign w_fa_sum   = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_fa_cout  = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
  assign w_res_next = {w_fa_sum, r_res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_carry  <= w_fa_cout;
      r_res_sh <= w_res_next;
      r_cnt    <= r_cnt + CNT_W'(1);
      // Results are published only on the final bit, never partially.
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_fa_cout;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// Scoreboarded random/directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=13.
`default_nettype none

module tb_serial_add_ctrl;

  typedef struct {
    logic [63:0] exp;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_v[2];
  logic [31:0] b_v[2];
  logic        start_v[2];
  logic        cin_v[2];
  logic        sub_v[2];

  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy13, done13, cout13;
  logic [12:0] sum13;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_len[2];
  bit   prev_done[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub_v[0]),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .a(a_v[1][12:0]), .b(b_v[1][12:0]), .cin(cin_v[1]),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub_v[1]),
`endif
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
  );

  function automatic int wof(input int d);
    return (d == 0) ? 8 : 13;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy8 : busy13;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic modulo 2^(W+1).
  function automatic logic [63:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic sb);
    logic [63:0] m, m2, x, y;
    m  = (64'd1 << w) - 64'd1;
    m2 = (64'd1 << (w + 1)) - 64'd1;
    x  = {32'd0, av} & m;
    y  = {32'd0, bv} & m;
`ifdef SERIAL_ADD_SUB_EN
    if (sb) return (x + (m - y) + 64'd1) & m2;
`endif
    return (x + y + {63'd0, ci}) & m2;
  endfunction

  task automatic issue(input int d, input logic [31:0] av, input logic [31:0] bv, input logic ci,
                       input logic sb, input bit hold, input bit push, input bit noise);
    int   guard;
    logic [31:0] m;
    exp_t e;
    m = (d == 0) ? 32'hFF : 32'h1FFF;
    guard = 0;
    @(negedge clk);
    while (get_busy(d) && guard < 100) begin
      if (noise) begin
        start_v[d] = 1'($urandom_range(0, 1));
        a_v[d]     = $urandom;
        b_v[d]     = $urandom;
        cin_v[d]   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("issue_wait_timeout", 64'd1, 64'd0);
    a_v[d]     = av & m;
    b_v[d]     = bv & m;
    cin_v[d]   = ci;
    sub_v[d]   = sb;
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    e.exp = model(wof(d), av, bv, ci, sb);
    e.cyc = cyc;
    if (push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    if (!hold) begin
      @(negedge clk);
      start_v[d] = 1'b0;
    end
  endtask

  task automatic drain(input int limit);
    int guard;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy8 || busy13) && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    check("drain_q8_empty", 64'(q0.size()), 64'd0);
    check("drain_q13_empty", 64'(q1.size()), 64'd0);
  endtask

  // Monitor: pops the expected response whenever a DUT signals done.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        bz, dn;
      logic [63:0] got;
      exp_t        e;
      bz  = (d == 0) ? busy8 : busy13;
      dn  = (d == 0) ? done8 : done13;
      got = (d == 0) ? {55'd0, cout8, sum8} : {50'd0, cout13, sum13};
      if (!rst_n) begin
        busy_len[d]  = 0;
        prev_done[d] = 1'b0;
      end else begin
        if (dn) begin
          check("done_not_with_busy", {63'd0, bz}, 64'd0);
          check("done_one_cycle", {63'd0, prev_done[d]}, 64'd0);
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done dut%0d: got done=1 expected no pending op", wof(d));
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check((d == 0) ? "result_w8" : "result_w13", got, e.exp);
            check("latency", 64'(cyc - e.cyc), 64'(wof(d)));
          end
        end
        if (bz) begin
          busy_len[d]++;
        end else if (busy_len[d] != 0) begin
          check("busy_length", 64'(busy_len[d]), 64'(wof(d)));
          busy_len[d] = 0;
        end
        prev_done[d] = dn;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      a_v[d] = '0; b_v[d] = '0; start_v[d] = 1'b0; cin_v[d] = 1'b0; sub_v[d] = 1'b0;
      busy_len[d] = 0; prev_done[d] = 1'b0;
    end
    #12;
    check("rst_busy", {63'd0, busy8}, 64'd0);
    check("rst_done", {63'd0, done8}, 64'd0);
    check("rst_sum_cout", {55'd0, cout8, sum8}, 64'd0);
    check("rst_sum_cout_w13", {50'd0, cout13, sum13}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(0, 32'h00, 32'h00, 1'b0, 1'b0, 0, 1, 0);
    issue(0, 32'hFF, 32'h01, 1'b0, 1'b0, 0, 1, 0);
    issue(0, 32'hA5, 32'h5A, 1'b1, 1'b0, 0, 1, 0);
    // Hold start and scramble operands during RUN; the next op follows back-to-back.
    issue(0, 32'h12, 32'h34, 1'b0, 1'b0, 1, 1, 0);
    @(negedge clk);
    a_v[0] = 32'hFF;
    b_v[0] = 32'hFF;
    issue(0, 32'hFF, 32'hFF, 1'b0, 1'b0, 0, 1, 0);
    drain(100);

    // Abort mid-RUN with reset; the earlier FE/1 result must vanish.
    issue(0, 32'h0F, 32'h01, 1'b0, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy8}, 64'd0);
    check("abort_done", {63'd0, done8}, 64'd0);
    check("abort_sum_cout", {55'd0, cout8, sum8}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) dn++;
    end
    check("no_done_after_abort", 64'(dn), 64'd0);
    check("idle_after_abort", {63'd0, busy8}, 64'd0);

`ifdef SERIAL_ADD_SUB_EN
    issue(0, 32'h10, 32'h01, 1'b0, 1'b1, 0, 1, 0);
    issue(0, 32'h01, 32'h02, 1'b1, 1'b1, 0, 1, 0);
    drain(100);
`endif

    fork
      begin
        repeat (200) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          issue(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1, 1);
        end
      end
      begin
        repeat (200) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          issue(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1, 1);
        end
      end
    join
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. Time-shares one instance of the team's 1-bit fulladder cell (ports A, B, Cin, Sum, Cout) to add two WIDTH-bit operands, one bit per clock, LSB first. Uses a start/busy/done handshake. Sits beside the combinational adder library as the area-minimal alternative to a ripple-carry adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  registered result; holds until the next completion
cout  output  1  registered final carry; holds until the next completion

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry register and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge (T0) latches a->a_sh, b->b_sh, cin->carry, and sets cnt=0. Next state is RUN; busy=1 from T0.
- RUN, each edge:
  - fulladder inputs are A=a_sh[0], B=b_sh[0], Cin=carry.
  - Sum bit shifts into the MSB of res_sh (shift right).
  - carry<=Cout.
  - a_sh and b_sh shift right.
  - cnt<=cnt+1.
- RUN exit: at the edge where cnt==WIDTH-1 (edge T0+WIDTH):
  - sum<=final res_sh, cout<=Cout.
  - state->DONE, busy->0, done->1.
- Latency: done is high in the cycle after edge T0+WIDTH, i.e. exactly WIDTH cycles after start is accepted.
- DONE: lasts exactly one cycle.
  - start=0: go to IDLE.
  - start=1: accepted as in IDLE, go straight to RUN (back-to-back; done and the new busy are not both high).
- start during RUN: ignored; operands and carry are not disturbed.
- a, b and cin may change freely after capture.
- sum/cout never show partial results; they change only on the RUN->DONE edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- Reset mid-RUN: aborts immediately. Outputs go to reset values, and the previous sum/cout are lost.
- Combinational fulladder outputs feed registers only; no combinational path from any input to any output.

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured on accepted start.
  - sub=1: b_sh loads ~b and carry loads 1; cin is ignored.
  - Result: {cout,sum} = a - b with cout=1 meaning no borrow.
  - sub=0: identical to the base behaviour.
- Undefined: port sub is absent; addition only.

Test Plan:
- WIDTH=8; a=8'h00, b=8'h00, cin=0, start pulse -> done high 8 cycles after acceptance; sum=8'h00, cout=0; busy high for exactly 8 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Also a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
- Start a=8'h12, b=8'h34. Hold start=1 and change a/b to 8'hFF/8'hFF during RUN -> result is sum=8'h46, cout=0. Because start is still high in DONE, a second op on 8'hFF+8'hFF begins back-to-back and gives sum=8'hFE, cout=1 eight cycles later.
- Run 8'h0F+8'h01, then assert rst_n=0 at RUN cycle 4 -> busy, done, sum and cout all 0 immediately. After release: IDLE, and no done pulse appears.
- Randomised 200 operations at WIDTH=8 and WIDTH=13 -> {cout,sum} matches a+b+cin each time; done is always exactly one cycle.
- With SERIAL_ADD_SUB_EN, sub=1: a=8'h10, b=8'h01 -> sum=8'h0F, cout=1. a=8'h01, b=8'h02 -> sum=8'hFF, cout=0.
